// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Sequences one 1-bit full-adder slice over two WIDTH-bit operands, LSB
// first, one bit per clock. Owns the operand shift registers, the carry
// flop, the bit counter and the start/busy/done handshake.
// WIDTH legal range is 2..32.
// Optional feature macro: SERIAL_ADD_SUB_EN adds a 'sub' input that turns
// the operation into a - b (B inverted on capture, carry preloaded with 1).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // The single full-adder slice: the only arithmetic in the block.
  logic slice_sum;
  logic slice_carry;
  assign slice_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign slice_carry = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

  // Operand conditioning applied on capture (subtract = add inverted B plus 1).
  logic [WIDTH-1:0] b_capture;
  logic             carry_capture;
`ifdef SERIAL_ADD_SUB_EN
  assign b_capture     = sub ? ~b : b;
  assign carry_capture = sub ? 1'b1 : cin;
`else
  assign b_capture     = b;
  assign carry_capture = cin;
`endif

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path through
    // the case statement leaves one unassigned (which would infer a latch).
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b_capture;
          carry_d  = carry_capture;
          res_sh_d = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        // Slice sum enters at the MSB so bit 0 ends up at the LSB after WIDTH shifts.
        res_sh_d = {slice_sum, res_sh_q[WIDTH-1:1]};
        carry_d  = slice_carry;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        if (cnt_q == LAST_BIT) begin
          // Publish only the complete result; the counter stops at terminal count.
          sum_d   = {slice_sum, res_sh_q[WIDTH-1:1]};
          cout_d  = slice_carry;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: every register, including the shift registers, is reset so an
      // aborted operation leaves no stale operand or partial-sum bits behind.
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Handshake outputs are pure decodes of the registered state.
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: directed and random operations, results
// predicted from plain arithmetic and checked by a scoreboard monitor.
module tb_serial_add_ctrl;

  localparam int W = 8;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: {cout,sum} = a + b + cin; subtract gives a - b with cout = no borrow.
  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic ci, input logic sb);
    longint unsigned x = longint'(av);
    longint unsigned y = longint'(bv);
    longint unsigned t;
    logic [W:0] r;
    if (sb && SUB_EN) begin
      t = x - y;
      r = {(x >= y), t[W-1:0]};
    end else begin
      t = x + y + longint'(ci);
      r = t[W:0];
    end
    return r;
  endfunction

  // Monitor: checks reset state, busy length, done results and result hold.
  initial begin : monitor
    logic       r;
    int         busy_cnt;
    logic [W:0] hold;
    busy_cnt = 0;
    hold     = '0;
    forever begin
      @(posedge clk);
      r = rst;
      @(negedge clk);
      if (r) begin
        check("reset_state", {busy, done, cout, sum}, '0);
        busy_cnt = 0;
        hold     = '0;
      end else begin
        if (busy) begin
          busy_cnt++;
        end else if (busy_cnt != 0) begin
          check("busy_len", busy_cnt, W);
          check("done_after_busy", done, 1);
          busy_cnt = 0;
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            fail_now("spurious_done");
          end else begin
            hold = exp_q.pop_front();
            check("result", {cout, sum}, hold);
          end
        end else begin
          check("hold", {cout, sum}, hold);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) fail_now("timeout_idle");
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) fail_now("timeout_done");
  endtask

  // Issue one accepted start; returns one cycle after acceptance.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb);
    wait_idle();
    a     = av;
    b     = bv;
    cin   = ci;
`ifdef SERIAL_ADD_SUB_EN
    sub   = sb;
`endif
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(av, bv, ci, sb));
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'($urandom);
`endif
  endtask

  initial begin : stimulus
    int n;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    // Two reset edges with inputs and start toggling: nothing may be accepted.
    @(posedge clk); #1;
    a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b1, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0);

    // Starts during RUN and during DONE are ignored.
    run_op(8'h12, 8'h34, 1'b1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    a = 8'hEE; b = 8'h77; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    // Reset four cycles into RUN aborts; a fresh start then completes.
    run_op(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(8'h03, 8'h04, 1'b1, 1'b0);

    if (SUB_EN) begin
      run_op(8'h10, 8'h01, 1'b0, 1'b1);
      run_op(8'h01, 8'h02, 1'b1, 1'b1);
      run_op(8'h10, 8'h01, 1'b0, 1'b0);
      run_op(8'h80, 8'h80, 1'b0, 1'b1);
    end

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    // Drain the scoreboard within a bounded time.
    n = 0;
    while ((exp_q.size() != 0 || busy || done) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
